// File: rtl/datapath_param.sv
// datapath_param
// Parametrised accumulator / carry / register-file datapath for the CPU core.
// It sits between the instruction decoder and the bus interface. The decoder
// drives the control strobes. The bus interface supplies bus data and
// register-pair loads.
//
// Optional feature: define DATAPATH_DAA_EN to turn alu_op 8 into a decimal
// adjust of the accumulator. With the macro undefined, op 8 passes the
// accumulator through and no +6 adjust adder is built.
//
// Ports
//   clock, reset_n        rising-edge clock; synchronous active-low reset
//   halt                  freezes acc, carry, registers, pair FSM and the
//                         TEST synchroniser (reset still wins)
//   data, imm             bus operand and instruction immediate
//   reg_addr              register select for reads and single writes
//   acc_sel/acc_we/acc_clr                  accumulator source and strobes
//   carry_we/carry_clr/carry_set            carry strobes (clr > set > we)
//   reg_we/reg_sel                          single register write
//   alu_op, alu_in0_sel, alu_in1_sel, alu_cin_sel   ALU control
//   test, cond            asynchronous TEST pin and branch condition mask
//   pair_wr_valid/addr/data, pair_wr_ready  two-cycle register-pair write
//   regval, pairval, reg_is_zero            register read-back
//   acc, carry, take_branch                 architectural state and branch
module datapath_param #(
    parameter int DATA_W   = 4,
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  halt,
    input  logic [DATA_W-1:0]     data,
    input  logic [DATA_W-1:0]     imm,
    input  logic [REG_AW-1:0]     reg_addr,
    input  logic [2:0]            acc_sel,
    input  logic                  acc_we,
    input  logic                  acc_clr,
    input  logic                  carry_we,
    input  logic                  carry_clr,
    input  logic                  carry_set,
    input  logic                  reg_we,
    input  logic [1:0]            reg_sel,
    input  logic [3:0]            alu_op,
    input  logic [1:0]            alu_in0_sel,
    input  logic [1:0]            alu_in1_sel,
    input  logic [1:0]            alu_cin_sel,
    input  logic                  test,
    input  logic [3:0]            cond,
    input  logic                  pair_wr_valid,
    input  logic [REG_AW-2:0]     pair_wr_addr,
    input  logic [2*DATA_W-1:0]   pair_wr_data,
    output logic                  pair_wr_ready,
    output logic [DATA_W-1:0]     regval,
    output logic [2*DATA_W-1:0]   pairval,
    output logic [DATA_W-1:0]     acc,
    output logic                  carry,
    output logic                  take_branch,
    output logic                  reg_is_zero
);

    typedef enum logic {IDLE, HIGH2} pair_state_t;

    pair_state_t             state, state_nxt;
    logic [DATA_W-1:0]       regs [NUM_REGS];
    logic [REG_AW-2:0]       pair_p;
    logic [DATA_W-1:0]       pair_lo;
    logic                    pair_hi_we, pair_lo_we, pair_we;
    logic [REG_AW-1:0]       pair_waddr;
    logic [DATA_W-1:0]       pair_wdata;
    logic                    test_p0, test_p1;
    logic [DATA_W-1:0]       alu_in0, alu_in1;
    logic                    alu_cin;
    logic [DATA_W:0]         alu_res, daa_res;
    logic [DATA_W-1:0]       acc_src, reg_wdata;
    logic                    reg_wr_en, branch_t;

`ifdef DATAPATH_DAA_EN
    // Decimal adjust of the low nibble. Upper bits pass through unchanged.
    function automatic logic [DATA_W:0] daa_f(input logic [DATA_W-1:0] a,
                                              input logic cy);
        logic [DATA_W:0] r;
        logic [4:0]      lo;
        if (a[3:0] > 4'd9 || cy) begin
            lo        = {1'b0, a[3:0]} + 5'd6;
            r         = {1'b0, a};
            r[3:0]    = lo[3:0];
            r[DATA_W] = lo[4] | cy;
        end else begin
            r = {cy, a};
        end
        return r;
    endfunction
`endif

    function automatic logic [DATA_W:0] alu_f(input logic [3:0] op,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic ci,
                                              input logic [DATA_W:0] daa);
        logic [DATA_W:0] r;
        case (op)
            4'd0:    r = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, ci};
            // Carry out of SUB is "no borrow".
            4'd1:    r = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, ci};
            4'd2:    r = {1'b0, a & b};
            4'd3:    r = {1'b0, a | b};
            4'd4:    r = {1'b0, a ^ b};
            4'd5:    r = {a, ci};
            4'd6:    r = {a[0], ci, a[DATA_W-1:1]};
            4'd8:    r = daa;
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    // ALU operand selection and evaluation
    always_comb begin
        case (alu_in0_sel)
            2'd0:    alu_in0 = acc;
            2'd1:    alu_in0 = regval;
            2'd2:    alu_in0 = data;
            default: alu_in0 = '0;
        endcase
        case (alu_in1_sel)
            2'd0:    alu_in1 = regval;
            2'd1:    alu_in1 = data;
            2'd2:    alu_in1 = imm;
            default: alu_in1 = '0;
        endcase
        case (alu_cin_sel)
            2'd0:    alu_cin = 1'b0;
            2'd1:    alu_cin = 1'b1;
            2'd2:    alu_cin = carry;
            default: alu_cin = ~carry;
        endcase
`ifdef DATAPATH_DAA_EN
        daa_res = daa_f(acc, carry);
`else
        daa_res = {1'b0, acc};
`endif
        alu_res = alu_f(alu_op, alu_in0, alu_in1, alu_cin, daa_res);
    end

    always_comb begin
        case (acc_sel)
            3'd0:    acc_src = regval;
            3'd1:    acc_src = data;
            3'd2:    acc_src = alu_res[DATA_W-1:0];
            3'd3:    acc_src = imm;
            3'd4:    acc_src = {{(DATA_W-1){1'b0}}, carry};
            3'd5:    acc_src = carry ? DATA_W'(10) : DATA_W'(9);
            default: acc_src = acc;
        endcase
        case (reg_sel)
            2'd0:    reg_wdata = acc;
            2'd1:    reg_wdata = alu_res[DATA_W-1:0];
            default: reg_wdata = data;
        endcase
        reg_wr_en = reg_we && (reg_sel != 2'd3);
    end

    // Pair-write FSM: high half goes out on acceptance, low half one cycle later
    always_comb begin
        state_nxt     = state;
        pair_wr_ready = 1'b0;
        pair_hi_we    = 1'b0;
        pair_lo_we    = 1'b0;
        pair_waddr    = '0;
        pair_wdata    = '0;
        case (state)
            IDLE: begin
                pair_wr_ready = 1'b1;
                if (pair_wr_valid && !halt) begin
                    pair_hi_we = 1'b1;
                    pair_waddr = {pair_wr_addr, 1'b0};
                    pair_wdata = pair_wr_data[2*DATA_W-1:DATA_W];
                    state_nxt  = HIGH2;
                end
            end
            HIGH2: begin
                if (!halt) begin
                    pair_lo_we = 1'b1;
                    pair_waddr = {pair_p, 1'b1};
                    pair_wdata = pair_lo;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        pair_we = pair_hi_we | pair_lo_we;
    end

    always_ff @(posedge clock) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (pair_hi_we) begin
            pair_p  <= pair_wr_addr;
            pair_lo <= pair_wr_data[DATA_W-1:0];
        end
    end

    // Register file: the pair write is issued last so that it wins a
    // same-register collision with a single write in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (!halt) begin
            if (reg_wr_en)
                regs[reg_addr] <= reg_wdata;
            if (pair_we)
                regs[pair_waddr] <= pair_wdata;
        end
    end

    // Accumulator, carry and TEST synchroniser
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc     <= '0;
            carry   <= 1'b1;
            test_p0 <= 1'b0;
            test_p1 <= 1'b0;
        end else if (!halt) begin
            if (acc_clr)
                acc <= '0;
            else if (acc_we)
                acc <= acc_src;
            if (carry_clr)
                carry <= 1'b0;
            else if (carry_set)
                carry <= 1'b1;
            else if (carry_we)
                carry <= alu_res[DATA_W];
            test_p0 <= test;
            test_p1 <= test_p0;
        end
    end

    // Read-back and branch evaluation
    always_comb begin
        regval      = regs[reg_addr];
        pairval     = {regs[{reg_addr[REG_AW-1:1], 1'b0}],
                       regs[{reg_addr[REG_AW-1:1], 1'b1}]};
        reg_is_zero = (regval == '0);
        branch_t    = (cond[0] & test_p1) | (cond[1] & carry) |
                      (cond[2] & (acc == '0));
        take_branch = cond[3] ? ~branch_t : branch_t;
    end

endmodule

// File: tb/tb_datapath_param.sv
// Directed bench for datapath_param: a table of single-cycle vectors for the
// acc/carry/ALU paths, then hand-written sequences for the pair-write FSM,
// halt, write conflicts, TEST synchroniser latency and reset mid-pair.
module tb_datapath_param;
    localparam int DATA_W   = 4;
    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;

    logic                clock = 1'b0;
    logic                reset_n, halt;
    logic [DATA_W-1:0]   data, imm;
    logic [REG_AW-1:0]   reg_addr;
    logic [2:0]          acc_sel;
    logic                acc_we, acc_clr, carry_we, carry_clr, carry_set, reg_we;
    logic [1:0]          reg_sel;
    logic [3:0]          alu_op;
    logic [1:0]          alu_in0_sel, alu_in1_sel, alu_cin_sel;
    logic                test;
    logic [3:0]          cond;
    logic                pair_wr_valid;
    logic [REG_AW-2:0]   pair_wr_addr;
    logic [2*DATA_W-1:0] pair_wr_data;
    logic                pair_wr_ready;
    logic [DATA_W-1:0]   regval;
    logic [2*DATA_W-1:0] pairval;
    logic [DATA_W-1:0]   acc;
    logic                carry, take_branch, reg_is_zero;

    int checks = 0;
    int errors = 0;

    always #10 clock = ~clock;

    datapath_param #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clock(clock), .reset_n(reset_n), .halt(halt), .data(data), .imm(imm),
        .reg_addr(reg_addr), .acc_sel(acc_sel), .acc_we(acc_we), .acc_clr(acc_clr),
        .carry_we(carry_we), .carry_clr(carry_clr), .carry_set(carry_set),
        .reg_we(reg_we), .reg_sel(reg_sel), .alu_op(alu_op),
        .alu_in0_sel(alu_in0_sel), .alu_in1_sel(alu_in1_sel),
        .alu_cin_sel(alu_cin_sel), .test(test), .cond(cond),
        .pair_wr_valid(pair_wr_valid), .pair_wr_addr(pair_wr_addr),
        .pair_wr_data(pair_wr_data), .pair_wr_ready(pair_wr_ready),
        .regval(regval), .pairval(pairval), .acc(acc), .carry(carry),
        .take_branch(take_branch), .reg_is_zero(reg_is_zero)
    );

    typedef struct {
        logic       halt;
        logic [2:0] acc_sel;
        logic       acc_we, acc_clr, carry_we, carry_clr, carry_set;
        logic       reg_we;
        logic [1:0] reg_sel;
        logic [3:0] alu_op;
        logic [1:0] in0, in1, cin;
        logic [3:0] data, imm, raddr;
        logic       chk_reg;
        logic [3:0] exp_reg, exp_acc;
        logic       exp_carry;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input vec_t t);
        vecs.push_back(t);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        acc_sel = 0; acc_we = 0; acc_clr = 0; carry_we = 0; carry_clr = 0;
        carry_set = 0; reg_we = 0; reg_sel = 0; alu_op = 0; alu_in0_sel = 0;
        alu_in1_sel = 0; alu_cin_sel = 0; data = 0; imm = 0;
        pair_wr_valid = 0; pair_wr_addr = 0; pair_wr_data = 0;
    endtask

    initial begin
        logic [3:0] daa_a1, daa_a2;
        logic       daa_c1, daa_c2;
`ifdef DATAPATH_DAA_EN
        daa_a1 = 4'h1; daa_c1 = 1'b1;   // 0xB + 6 = 0x11
        daa_a2 = 4'h3; daa_c2 = 1'b1;   // 0xD + 6 = 0x13
`else
        daa_a1 = 4'hB; daa_c1 = 1'b0;
        daa_a2 = 4'hD; daa_c2 = 1'b0;
`endif
        // ALU op / in0 / in1 / cin codes follow the port definitions.
        add('{default:0, acc_sel:3, acc_we:1, imm:9, exp_acc:9, exp_carry:1});
        add('{default:0, reg_we:1, reg_sel:2, data:8, raddr:3, chk_reg:1, exp_reg:8, exp_acc:9, exp_carry:1});
        add('{default:0, alu_op:0, raddr:3, acc_sel:2, acc_we:1, carry_we:1, chk_reg:1, exp_reg:8, exp_acc:1, exp_carry:1});
        add('{default:0, acc_sel:3, acc_we:1, imm:9, raddr:3, exp_acc:9, exp_carry:1});
        add('{default:0, alu_op:1, cin:1, raddr:3, acc_sel:2, acc_we:1, carry_we:1, exp_acc:1, exp_carry:1});
        add('{default:0, carry_clr:1, carry_set:1, carry_we:1, exp_acc:1, exp_carry:0});
        add('{default:0, carry_set:1, carry_we:1, alu_op:0, in1:3, exp_acc:1, exp_carry:1});
        add('{default:0, acc_sel:5, acc_we:1, exp_acc:4'hA, exp_carry:1});
        add('{default:0, carry_clr:1, exp_acc:4'hA, exp_carry:0});
        add('{default:0, acc_sel:5, acc_we:1, exp_acc:9, exp_carry:0});
        add('{default:0, acc_sel:4, acc_we:1, exp_acc:0, exp_carry:0});
        add('{default:0, acc_sel:3, acc_we:1, imm:5, exp_acc:5, exp_carry:0});
        add('{default:0, acc_sel:3, acc_we:1, acc_clr:1, imm:7, exp_acc:0, exp_carry:0});
        add('{default:0, acc_sel:3, acc_we:1, carry_set:1, imm:4'hC, exp_acc:4'hC, exp_carry:1});
        add('{default:0, alu_op:2, in1:2, imm:4'hA, acc_sel:2, acc_we:1, carry_we:1, exp_acc:8, exp_carry:0});
        add('{default:0, alu_op:3, in1:1, data:3, acc_sel:2, acc_we:1, carry_we:1, exp_acc:4'hB, exp_carry:0});
        add('{default:0, alu_op:4, in1:2, imm:4'hF, acc_sel:2, acc_we:1, carry_we:1, exp_acc:4, exp_carry:0});
        add('{default:0, alu_op:5, cin:1, acc_sel:2, acc_we:1, carry_we:1, exp_acc:9, exp_carry:0});
        add('{default:0, alu_op:6, cin:2, acc_sel:2, acc_we:1, carry_we:1, exp_acc:4, exp_carry:1});
        add('{default:0, alu_op:5, cin:3, acc_sel:2, acc_we:1, carry_we:1, exp_acc:8, exp_carry:0});
        add('{default:0, acc_sel:6, acc_we:1, exp_acc:8, exp_carry:0});
        add('{default:0, reg_we:1, reg_sel:3, raddr:3, chk_reg:1, exp_reg:8, exp_acc:8, exp_carry:0});
        add('{default:0, reg_we:1, reg_sel:0, raddr:7, chk_reg:1, exp_reg:8, exp_acc:8, exp_carry:0});
        add('{default:0, reg_we:1, reg_sel:1, raddr:6, alu_op:0, in1:2, imm:9, chk_reg:1, exp_reg:1, exp_acc:8, exp_carry:0});
        add('{default:0, carry_set:1, exp_acc:8, exp_carry:1});
        add('{default:0, alu_op:7, in0:2, data:6, acc_sel:2, acc_we:1, carry_we:1, exp_acc:6, exp_carry:0});
        add('{default:0, carry_set:1, exp_acc:6, exp_carry:1});
        add('{default:0, alu_op:12, in0:1, raddr:7, acc_sel:2, acc_we:1, carry_we:1, chk_reg:1, exp_reg:8, exp_acc:8, exp_carry:0});
        add('{default:0, acc_sel:3, acc_we:1, imm:4'hB, exp_acc:4'hB, exp_carry:0});
        add('{default:0, alu_op:8, acc_sel:2, acc_we:1, carry_we:1, exp_acc:daa_a1, exp_carry:daa_c1});
        add('{default:0, acc_sel:3, acc_we:1, imm:2, exp_acc:2, exp_carry:daa_c1});
        add('{default:0, alu_op:1, in1:2, imm:5, cin:1, acc_sel:2, acc_we:1, carry_we:1, exp_acc:4'hD, exp_carry:0});
        add('{default:0, halt:1, acc_sel:3, acc_we:1, imm:3, carry_set:1, exp_acc:4'hD, exp_carry:0});
        add('{default:0, carry_set:1, exp_acc:4'hD, exp_carry:1});
        add('{default:0, alu_op:8, acc_sel:2, acc_we:1, carry_we:1, exp_acc:daa_a2, exp_carry:daa_c2});
        add('{default:0, acc_sel:3, acc_we:1, imm:4, carry_clr:1, exp_acc:4, exp_carry:0});
        add('{default:0, alu_op:8, acc_sel:2, acc_we:1, carry_we:1, exp_acc:4, exp_carry:0});

        // Reset with halt asserted: reset must win.
        idle();
        reset_n = 0; halt = 1; test = 0; cond = 0; reg_addr = 0;
        step();
        chk("rst_acc", acc, 0);
        chk("rst_carry", carry, 1);
        chk("rst_ready", pair_wr_ready, 1);
        chk("rst_take", take_branch, 0);
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_addr = REG_AW'(i);
            step();
            chk($sformatf("rst_reg%0d", i), regval, 0);
        end
        reset_n = 1; halt = 0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < vecs.size(); i++) begin
            halt = vecs[i].halt; acc_sel = vecs[i].acc_sel; acc_we = vecs[i].acc_we;
            acc_clr = vecs[i].acc_clr; carry_we = vecs[i].carry_we;
            carry_clr = vecs[i].carry_clr; carry_set = vecs[i].carry_set;
            reg_we = vecs[i].reg_we; reg_sel = vecs[i].reg_sel; alu_op = vecs[i].alu_op;
            alu_in0_sel = vecs[i].in0; alu_in1_sel = vecs[i].in1; alu_cin_sel = vecs[i].cin;
            data = vecs[i].data; imm = vecs[i].imm; reg_addr = vecs[i].raddr;
            step();
            chk($sformatf("vec%0d_acc", i), acc, vecs[i].exp_acc);
            chk($sformatf("vec%0d_carry", i), carry, vecs[i].exp_carry);
            if (vecs[i].chk_reg)
                chk($sformatf("vec%0d_reg", i), regval, vecs[i].exp_reg);
        end
        halt = 0;
        idle();

        // Branch evaluation
        acc_clr = 1; step(); acc_clr = 0;
        cond = 4'h4; settle(); chk("br_acc0", take_branch, 1);
        cond = 4'hC; settle(); chk("br_acc0_inv", take_branch, 0);
        cond = 4'h0; settle(); chk("br_none", take_branch, 0);
        cond = 4'h8; settle(); chk("br_always", take_branch, 1);
        cond = 4'h2; settle(); chk("br_carry0", take_branch, 0);
        carry_set = 1; step(); carry_set = 0;
        chk("br_carry1", take_branch, 1);
        cond = 4'hA; settle(); chk("br_carry1_inv", take_branch, 0);
        cond = 4'h1; test = 0; step(); step();
        chk("br_test_low", take_branch, 0);
        test = 1; step();
        chk("br_test_1cyc", take_branch, 0);
        step();
        chk("br_test_2cyc", take_branch, 1);
        test = 0; step();
        chk("br_test_hold", take_branch, 1);
        step();
        chk("br_test_fall", take_branch, 0);
        cond = 0;

        // Basic pair write
        pair_wr_valid = 1; pair_wr_addr = 2; pair_wr_data = 8'hA5; reg_addr = 4;
        step(); pair_wr_valid = 0; settle();
        chk("pair_hi", regval, 4'hA);
        chk("pair_busy", pair_wr_ready, 0);
        reg_addr = 5; settle();
        chk("pair_lo_pending", regval, 0);
        chk("pair_lo_zero_flag", reg_is_zero, 1);
        step();
        chk("pair_lo", regval, 4'h5);
        chk("pair_ready_back", pair_wr_ready, 1);
        reg_addr = 4; settle();
        chk("pairval", pairval, 8'hA5);

        // Halt while in the second phase
        pair_wr_valid = 1; pair_wr_addr = 2; pair_wr_data = 8'h3C;
        step(); pair_wr_valid = 0; halt = 1; settle();
        chk("halt_pair_hi", regval, 4'h3);
        reg_addr = 5;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("halt_lo_held%0d", i), regval, 4'h5);
            chk($sformatf("halt_ready%0d", i), pair_wr_ready, 0);
        end
        halt = 0; step();
        chk("halt_lo_done", regval, 4'hC);
        chk("halt_ready_back", pair_wr_ready, 1);

        // Back-to-back requests: one pair every two cycles
        reg_addr = 0; pair_wr_valid = 1; pair_wr_addr = 0; pair_wr_data = 8'h12;
        step();
        chk("b2b_hi1", regval, 4'h1);
        chk("b2b_busy1", pair_wr_ready, 0);
        pair_wr_data = 8'h34;
        step(); reg_addr = 1; settle();
        chk("b2b_lo1", regval, 4'h2);
        chk("b2b_ready1", pair_wr_ready, 1);
        step(); pair_wr_valid = 0; reg_addr = 0; settle();
        chk("b2b_hi2", regval, 4'h3);
        chk("b2b_busy2", pair_wr_ready, 0);
        step(); reg_addr = 1; settle();
        chk("b2b_lo2", regval, 4'h4);

        // Write conflicts; acc = 3 is the single-write source
        acc_sel = 3; imm = 3; acc_we = 1; step(); idle();
        pair_wr_valid = 1; pair_wr_addr = 2; pair_wr_data = 8'h7E;
        reg_we = 1; reg_sel = 0; reg_addr = 4;
        step(); pair_wr_valid = 0; reg_we = 0; settle();
        chk("conf_hi_pair_wins", regval, 4'h7);
        reg_we = 1; reg_addr = 5;
        step(); reg_we = 0; settle();
        chk("conf_lo_pair_wins", regval, 4'hE);
        pair_wr_valid = 1; pair_wr_addr = 3; pair_wr_data = 8'h91;
        reg_we = 1; reg_addr = 4;
        step(); pair_wr_valid = 0; reg_we = 0; settle();
        chk("conf_other_reg", regval, 4'h3);
        reg_addr = 6; settle();
        chk("conf_other_pair_hi", regval, 4'h9);
        step(); reg_addr = 7; settle();
        chk("conf_other_pair_lo", regval, 4'h1);

        // Reset in the middle of a pair write
        pair_wr_valid = 1; pair_wr_addr = 1; pair_wr_data = 8'hFF; reg_addr = 2;
        step(); pair_wr_valid = 0; settle();
        chk("rmp_hi", regval, 4'hF);
        reset_n = 0;
        step();
        chk("rmp_hi_cleared", regval, 0);
        reg_addr = 3; settle();
        chk("rmp_lo_abandoned", regval, 0);
        chk("rmp_ready", pair_wr_ready, 1);
        chk("rmp_acc", acc, 0);
        chk("rmp_carry", carry, 1);
        reset_n = 1;
        step();
        chk("rmp_no_resume", regval, 0);
        chk("rmp_zero_flag", reg_is_zero, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
